// File: rtl/mem_responder.sv
// Single-outstanding memory responder for the P_* request interface with modelled access latency.
// Optional next-word prefetch buffer enabled by defining MEM_RESP_PREFETCH_EN.
module mem_responder #(
   parameter int          DEPTH      = 1024,
   parameter int          LATENCY    = 3,
   parameter logic [31:0] RESET_DATA = 32'h13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        P_strobe,
   input  logic [31:0] P_addr,
   input  logic        P_rw,
   input  logic [31:0] P_wdata,
   output logic [31:0] P_data,
   output logic        P_ready,
   output logic        P_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);
   localparam bit DIRECT = (LATENCY == 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [AW-1:0] idx_q, req_idx, rd_idx;
   logic          rw_q, rd_rw;
   logic [31:0]   wdata_q, rd_data;
   logic          accept, enter_resp, pf_hit;
   logic          unused_addr;

   logic [31:0] mem [DEPTH];

   assign req_idx     = P_addr[AW+1:2];
   assign unused_addr = ^{P_addr[31:AW+2], P_addr[1:0]};
   assign accept      = (state == IDLE) && P_strobe;
   assign enter_resp  = (state_next == RESP);
   // A request entering RESP straight from IDLE has not been latched yet
   assign rd_idx      = (state == IDLE) ? req_idx : idx_q;
   assign rd_rw       = (state == IDLE) ? P_rw : rw_q;

`ifdef MEM_RESP_PREFETCH_EN
   logic          pf_valid;
   logic [AW-1:0] pf_idx, pf_next;
   logic [31:0]   pf_data;

   assign pf_next = idx_q + AW'(1);
   assign pf_hit  = accept && P_rw && pf_valid && (req_idx == pf_idx);
   assign rd_data = pf_hit ? pf_data : mem[rd_idx];

   always_ff @(posedge clk) begin
      if (!rst) begin
         pf_valid <= 1'b0;
         pf_idx   <= '0;
         pf_data  <= '0;
      end else if (state == RESP) begin
         if (rw_q) begin
            pf_valid <= 1'b1;
            pf_idx   <= pf_next;
            pf_data  <= mem[pf_next];
         end else if (idx_q == pf_idx) begin
            pf_valid <= 1'b0;
         end
      end
   end
`else
   assign pf_hit  = 1'b0;
   assign rd_data = mem[rd_idx];
`endif

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (P_strobe) begin
               if (DIRECT || pf_hit) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) state_next = RESP;
            else           cnt_next   = cnt - CW'(1);
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         rw_q    <= 1'b0;
         wdata_q <= '0;
         P_data  <= RESET_DATA;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept) begin
            idx_q   <= req_idx;
            rw_q    <= P_rw;
            wdata_q <= P_wdata;
         end
         // Read data is captured on the edge that enters RESP so it is visible with P_ready
         if (enter_resp && rd_rw) P_data <= rd_data;
      end
   end

   // Writes commit at the end of RESP; a reset on that edge discards them
   always_ff @(posedge clk) begin
      if (rst && (state == RESP) && !rw_q) mem[idx_q] <= wdata_q;
   end

   assign P_ready = (state == RESP);
   assign P_busy  = (state != IDLE);

endmodule
